// File: rtl/sim_result_checker_pkg.sv
// Shared types for the end-of-program detector / data-memory scoreboard.
package sim_result_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_value; never less than one bit.
  function automatic int unsigned count_width(input int unsigned max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/sim_result_checker_sat_counter.sv
// Clearable up-counter with a terminal-count flag; callers gate enable with
// !at_max to get saturating behaviour.
module sim_result_checker_sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/sim_result_checker.sv
// Waits for the fetch address to reach end-of-text, then walks DEPTH data words of
// the DUT and golden memories, counting mismatches under a RUN-state cycle budget.
module sim_result_checker
  import sim_result_checker_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 36,
  parameter int MAX_CYCLES = 100,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] eof_addr,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [ADDR_W-1:0] chk_idx,
  input  logic [DATA_W-1:0] dut_rdata,
  input  logic [DATA_W-1:0] ans_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_idx,
  output logic [DATA_W-1:0] err_dut,
  output logic [DATA_W-1:0] err_ans
);

  localparam int                CYC_W    = count_width(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] eof_lat_reg;
  logic [ADDR_W-1:0] chk_idx_reg;
  logic [ADDR_W-1:0] pipe_idx_reg;
  logic              pipe_valid_reg;
  logic              issued_all_reg;
  logic              timeout_reg;
  logic              err_valid_reg;
  logic [ADDR_W-1:0] err_idx_reg;
  logic [DATA_W-1:0] err_dut_reg;
  logic [DATA_W-1:0] err_ans_reg;

  logic [CYC_W-1:0]  cyc_cnt;
  logic              cyc_at_max;
  logic              err_at_max;

  logic start_accept;
  logic eof_hit;
  logic budget_hit;
  logic issue;
  logic mismatch;

  always_comb begin
    start_accept = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    eof_hit      = (state_reg == ST_RUN) && (inst_addr == eof_lat_reg);
    budget_hit   = (state_reg == ST_RUN) && (cyc_cnt == CYC_LAST);
    issue        = (state_reg == ST_CHECK) && !issued_all_reg;
    // Plain equality so an X on either read bus turns into an X mismatch in sim.
    mismatch     = pipe_valid_reg && (dut_rdata != ans_rdata);
  end

  sim_result_checker_sat_counter #(
    .WIDTH (CYC_W),
    .MAX   (MAX_CYCLES - 1)
  ) u_cyc_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_accept),
    .enable ((state_reg == ST_RUN) && !cyc_at_max),
    .count  (cyc_cnt),
    .at_max (cyc_at_max)
  );

  sim_result_checker_sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (DEPTH)
  ) u_err_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_accept),
    .enable (mismatch && !err_at_max),
    .count  (err_cnt),
    .at_max (err_at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_accept) state_next = ST_RUN;
      // eof has priority over the budget when both land on the same cycle
      ST_RUN:   if (eof_hit) state_next = ST_CHECK;
                else if (budget_hit) state_next = ST_DONE;
      ST_CHECK: if (issued_all_reg) state_next = ST_DONE;
      ST_DONE:  if (start_accept) state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ST_RUN) || (state_reg == ST_CHECK);
    done = (state_reg == ST_DONE);
    pass = done && !timeout_reg && (err_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eof_lat_reg    <= '0;
      timeout_reg    <= 1'b0;
      chk_idx_reg    <= '0;
      issued_all_reg <= 1'b0;
      pipe_valid_reg <= 1'b0;
      pipe_idx_reg   <= '0;
      err_valid_reg  <= 1'b0;
      err_idx_reg    <= '0;
      err_dut_reg    <= '0;
      err_ans_reg    <= '0;
    end else begin
      if (start_accept) begin
        eof_lat_reg <= eof_addr;
      end

      if (start_accept) begin
        timeout_reg <= 1'b0;
      end else if (budget_hit && !eof_hit) begin
        timeout_reg <= 1'b1;
      end

      // Index walk; returns to 0 once the last word is issued so it idles at 0.
      if (issue) begin
        issued_all_reg <= (chk_idx_reg == IDX_LAST);
        chk_idx_reg    <= (chk_idx_reg == IDX_LAST) ? '0 : chk_idx_reg + ADDR_W'(1);
      end else if (state_reg != ST_CHECK) begin
        issued_all_reg <= 1'b0;
        chk_idx_reg    <= '0;
      end

      pipe_valid_reg <= issue;
      pipe_idx_reg   <= chk_idx_reg;

      err_valid_reg <= mismatch;
      if (mismatch) begin
        err_idx_reg <= pipe_idx_reg;
        err_dut_reg <= dut_rdata;
        err_ans_reg <= ans_rdata;
      end
    end
  end

  assign chk_idx   = chk_idx_reg;
  assign timeout   = timeout_reg;
  assign err_valid = err_valid_reg;
  assign err_idx   = err_idx_reg;
  assign err_dut   = err_dut_reg;
  assign err_ans   = err_ans_reg;

endmodule
